// File: rtl/stm_access_arbiter_if.sv
// Bus bundle between the uP strobe source, the internal engine and the STM part.
// slave is the arbiter's view; master is the surrounding environment's view.
interface stm_access_arbiter_if;
  logic       Mpi_enb;
  logic       Mpi_rw;
  logic [5:0] Mpi_addr;
  logic [7:0] Mpi_wdata;
  logic [7:0] Mpi_rdata;
  logic       Mpi_rdata_vld;
  logic       Up_ovr;
  logic       Ovr_clr;
  logic       Int_req;
  logic       Int_rw;
  logic [5:0] Int_addr;
  logic [7:0] Int_wdata;
  logic       Int_gnt;
  logic [7:0] Int_rdata;
  logic       Int_rdata_vld;
  logic       Stm_enb;
  logic       Stm_rw;
  logic [5:0] Stm_addr;
  logic [7:0] Stm_wdata;
  logic [7:0] Stm_rdata;

  modport slave (
    input  Mpi_enb, Mpi_rw, Mpi_addr, Mpi_wdata, Ovr_clr,
           Int_req, Int_rw, Int_addr, Int_wdata, Stm_rdata,
    output Mpi_rdata, Mpi_rdata_vld, Up_ovr, Int_gnt, Int_rdata, Int_rdata_vld,
           Stm_enb, Stm_rw, Stm_addr, Stm_wdata
  );

  modport master (
    output Mpi_enb, Mpi_rw, Mpi_addr, Mpi_wdata, Ovr_clr,
           Int_req, Int_rw, Int_addr, Int_wdata, Stm_rdata,
    input  Mpi_rdata, Mpi_rdata_vld, Up_ovr, Int_gnt, Int_rdata, Int_rdata_vld,
           Stm_enb, Stm_rw, Stm_addr, Stm_wdata
  );
endinterface

// File: rtl/stm_access_arbiter.sv
// Two-requester arbiter for the single-port STM: uP strobes (1-deep pending slot,
// priority with bounded streak) and an internal level req/grant engine.
module stm_access_arbiter #(
  parameter int RD_LAT = 1,
  parameter int UP_MAX = 4
) (
  input  logic                  Clock,
  input  logic                  Rst_n,
  stm_access_arbiter_if.slave   bus
);
  localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam int SW = $clog2(UP_MAX + 1) < 1 ? 1 : $clog2(UP_MAX + 1);

  typedef enum logic [1:0] {IDLE, WR_ISS, RD_WAIT} state_e;
  typedef struct packed {
    logic       rw;
    logic [5:0] addr;
    logic [7:0] wdata;
  } acc_t;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] streak_q, streak_d;
  logic          pend_q, pend_d;
  acc_t          pend_a_q, pend_a_d;
  logic          up_ovr_q, up_ovr_d;
  logic          owner_int_q;
  logic          stm_enb_q, int_gnt_q;
  acc_t          stm_a_q;
  logic [7:0]    mpi_rdata_q, int_rdata_q;
  logic          mpi_vld_q, int_vld_q;

  acc_t mpi_a, int_a, up_a, gnt_a;
  logic idle, up_req, up_gnt, int_gnt, ovr_set;

  assign mpi_a   = {bus.Mpi_rw, bus.Mpi_addr, bus.Mpi_wdata};
  assign int_a   = {bus.Int_rw, bus.Int_addr, bus.Int_wdata};
  assign idle    = (state_q == IDLE);
  // The pending strobe is older than any strobe arriving now, so it goes first.
  assign up_req  = bus.Mpi_enb | pend_q;
  assign up_a    = pend_q ? pend_a_q : mpi_a;
  assign up_gnt  = idle & up_req & ((streak_q < SW'(UP_MAX)) | ~bus.Int_req);
  assign int_gnt = idle & ~up_gnt & bus.Int_req;
  assign gnt_a   = up_gnt ? up_a : int_a;

  always_comb begin
    pend_d   = pend_q;
    pend_a_d = pend_a_q;
    ovr_set  = 1'b0;
    if (pend_q & up_gnt) begin
      pend_d   = bus.Mpi_enb;
      pend_a_d = mpi_a;
    end else if (bus.Mpi_enb & ~up_gnt) begin
      if (pend_q) ovr_set = 1'b1;
      else begin
        pend_d   = 1'b1;
        pend_a_d = mpi_a;
      end
    end
    up_ovr_d = ovr_set | (up_ovr_q & ~bus.Ovr_clr);

    streak_d = streak_q;
    if (~bus.Int_req | int_gnt)                   streak_d = '0;
    else if (up_gnt && (streak_q < SW'(UP_MAX))) streak_d = streak_q + SW'(1);
  end

  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      pend_q   <= 1'b0;
      pend_a_q <= '0;
      up_ovr_q <= 1'b0;
      streak_q <= '0;
    end else begin
      pend_q   <= pend_d;
      pend_a_q <= pend_a_d;
      up_ovr_q <= up_ovr_d;
      streak_q <= streak_d;
    end
  end

  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_int_q <= 1'b0;
      stm_enb_q   <= 1'b0;
      stm_a_q     <= '0;
      int_gnt_q   <= 1'b0;
      mpi_rdata_q <= '0;
      int_rdata_q <= '0;
      mpi_vld_q   <= 1'b0;
      int_vld_q   <= 1'b0;
    end else begin
      stm_enb_q <= 1'b0;
      int_gnt_q <= 1'b0;
      mpi_vld_q <= 1'b0;
      int_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (up_gnt | int_gnt) begin
            stm_enb_q   <= 1'b1;
            stm_a_q     <= gnt_a;
            int_gnt_q   <= int_gnt;
            owner_int_q <= int_gnt;
            cnt_q       <= '0;
            state_q     <= gnt_a.rw ? RD_WAIT : WR_ISS;
          end
        end
        WR_ISS: state_q <= IDLE;
        RD_WAIT: begin
          // cnt_q counts cycles since the strobe; data is valid on the RD_LAT-th.
          if (cnt_q == CW'(RD_LAT)) begin
            state_q <= IDLE;
            if (owner_int_q) begin
              int_rdata_q <= bus.Stm_rdata;
              int_vld_q   <= 1'b1;
            end else begin
              mpi_rdata_q <= bus.Stm_rdata;
              mpi_vld_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Stm_enb       = stm_enb_q;
  assign bus.Stm_rw        = stm_a_q.rw;
  assign bus.Stm_addr      = stm_a_q.addr;
  assign bus.Stm_wdata     = stm_a_q.wdata;
  assign bus.Int_gnt       = int_gnt_q;
  assign bus.Int_rdata     = int_rdata_q;
  assign bus.Int_rdata_vld = int_vld_q;
  assign bus.Mpi_rdata     = mpi_rdata_q;
  assign bus.Mpi_rdata_vld = mpi_vld_q;
  assign bus.Up_ovr        = up_ovr_q;
endmodule
